// File: rtl/data_sram_like_bridge.sv
// Bridges the pipeline data port onto a sram-like bus: one bus transaction per core access,
// with the pipeline stalled until the transaction completes and load data held for MEM.
module data_sram_like_bridge #(
  parameter int ADDR_W   = 32,
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              stallreq,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        wstrb,
  output logic [31:0]       wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_req;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic              w_is_load;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic              w_data_done;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    w_is_load = (data_sram_wen == 4'b0000);
    case (data_sram_wen)
      4'b0011, 4'b1100:                   w_size = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = 2'd0;
      default:                            w_size = 2'd2;
    endcase
    w_addr = data_sram_addr;
    // kseg0/kseg1 (top bits 100/101) are unmapped windows onto physical address zero
    if (KSEG_MAP && (data_sram_addr[ADDR_W-1 -: 2] == 2'b10))
      w_addr[ADDR_W-1 -: 3] = 3'b000;
    if (w_is_load)
      w_addr[1:0] = 2'b00;
  end

  // data_ok counts only once the request has been accepted
  assign w_data_done = ((r_state == S_REQ) && addr_ok && data_ok) ||
                       ((r_state == S_WAIT) && data_ok);

  assign stallreq = ((r_state == S_IDLE) && data_sram_en) ||
                    (r_state == S_REQ) || (r_state == S_WAIT);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wstrb <= 4'b0000;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_sram_en) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_wr    <= !w_is_load;
            r_size  <= w_size;
            r_addr  <= w_addr;
            r_wstrb <= data_sram_wen;
            r_wdata <= data_sram_wdata;
          end
        end
        S_REQ: begin
          if (addr_ok) begin
            r_req   <= 1'b0;
            r_state <= data_ok ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_ok)
            r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_data_done && !r_wr)
        r_rdata <= rdata;
    end
  end

  assign req             = r_req;
  assign wr              = r_wr;
  assign size            = r_size;
  assign addr            = r_addr;
  assign wstrb           = r_wstrb;
  assign wdata           = r_wdata;
  assign data_sram_rdata = r_rdata;

endmodule
